// File: rtl/pipelined_main_memory.sv
// Shared instruction/data word memory with a read-only instruction port and a pipelined Wishbone data port.
// Responses come back after READ_LATENCY cycles, in order; wb_cyc low cancels outstanding data responses.
module pipelined_main_memory #(
  parameter string MEMORY_HEX   = "",
  parameter int    MEMORY_BYTES = 1024,
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 32,
  parameter int    READ_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   instr_addr,
  input  logic                    instr_stb,
  output logic                    instr_ack,
  output logic                    instr_err,
  output logic [DATA_WIDTH-1:0]   instr,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_wr_en,
  input  logic [ADDR_WIDTH-1:0]   wb_addr,
  input  logic [DATA_WIDTH-1:0]   wb_wr_data,
  input  logic [DATA_WIDTH/8-1:0] wb_wr_sel,
  output logic                    wb_stall,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic [DATA_WIDTH-1:0]   wb_rd_data
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
  localparam int DEPTH          = MEMORY_BYTES / BYTES_PER_WORD;
  localparam int OFF_W          = $clog2(BYTES_PER_WORD);
  localparam int IDX_W          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(MEMORY_BYTES);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Power-up image is all zeros; bus state is reset separately and the array itself never is.
  initial begin
    for (int k = 0; k < DEPTH; k++) mem_q[k] = '0;
  end

  logic             wb_take, wb_in_rng, i_in_rng;
  logic [IDX_W-1:0] wb_idx, i_idx;

  assign wb_stall  = rst;
  assign wb_take   = wb_cyc & wb_stb & ~rst;
  assign wb_in_rng = {1'b0, wb_addr} < LIMIT;
  assign i_in_rng  = {1'b0, instr_addr} < LIMIT;
  assign wb_idx    = wb_addr[OFF_W +: IDX_W];
  assign i_idx     = instr_addr[OFF_W +: IDX_W];

  always_ff @(posedge clk) begin
    if (wb_take && wb_wr_en && wb_in_rng) begin
      for (int b = 0; b < BYTES_PER_WORD; b++) begin
        if (wb_wr_sel[b]) mem_q[wb_idx][8*b +: 8] <= wb_wr_data[8*b +: 8];
      end
    end
  end

  // Accept-edge snapshot; reads see the pre-write word because the write above is non-blocking.
  logic                  wb_a_v, wb_a_err, wb_a_wr, i_a_v, i_a_err;
  logic [DATA_WIDTH-1:0] wb_a_data, i_a_data;

  assign wb_a_v    = wb_take;
  assign wb_a_err  = ~wb_in_rng;
  assign wb_a_wr   = wb_wr_en;
  assign wb_a_data = wb_in_rng ? mem_q[wb_idx] : '0;
  assign i_a_v     = instr_stb & ~rst;
  assign i_a_err   = ~i_in_rng;
  assign i_a_data  = i_in_rng ? mem_q[i_idx] : '0;

  logic                  wb_o_v, wb_o_err, wb_o_wr, i_o_v, i_o_err;
  logic [DATA_WIDTH-1:0] wb_o_data, i_o_data;

  if (READ_LATENCY == 1) begin : g_direct
    assign wb_o_v    = wb_a_v;
    assign wb_o_err  = wb_a_err;
    assign wb_o_wr   = wb_a_wr;
    assign wb_o_data = wb_a_data;
    assign i_o_v     = i_a_v;
    assign i_o_err   = i_a_err;
    assign i_o_data  = i_a_data;
  end else begin : g_pipe
    localparam int S = READ_LATENCY - 1;

    logic [S-1:0]          wb_v_q, wb_e_q, wb_w_q, i_v_q, i_e_q;
    logic [DATA_WIDTH-1:0] wb_d_q [S];
    logic [DATA_WIDTH-1:0] i_d_q  [S];

    always_ff @(posedge clk) begin
      for (int i = S - 1; i > 0; i--) begin
        wb_v_q[i] <= wb_v_q[i-1];
        wb_e_q[i] <= wb_e_q[i-1];
        wb_w_q[i] <= wb_w_q[i-1];
        wb_d_q[i] <= wb_d_q[i-1];
        i_v_q[i]  <= i_v_q[i-1];
        i_e_q[i]  <= i_e_q[i-1];
        i_d_q[i]  <= i_d_q[i-1];
      end
      wb_v_q[0] <= wb_a_v;
      wb_e_q[0] <= wb_a_err;
      wb_w_q[0] <= wb_a_wr;
      wb_d_q[0] <= wb_a_data;
      i_v_q[0]  <= i_a_v;
      i_e_q[0]  <= i_a_err;
      i_d_q[0]  <= i_a_data;
      if (rst || !wb_cyc) wb_v_q <= '0;
      if (rst) i_v_q <= '0;
    end

    assign wb_o_v    = wb_v_q[S-1];
    assign wb_o_err  = wb_e_q[S-1];
    assign wb_o_wr   = wb_w_q[S-1];
    assign wb_o_data = wb_d_q[S-1];
    assign i_o_v     = i_v_q[S-1];
    assign i_o_err   = i_e_q[S-1];
    assign i_o_data  = i_d_q[S-1];
  end

  logic                  wb_ack_q, wb_err_q, i_ack_q, i_err_q;
  logic [DATA_WIDTH-1:0] wb_rd_data_q, instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_ack_q     <= 1'b0;
      wb_err_q     <= 1'b0;
      wb_rd_data_q <= '0;
      i_ack_q      <= 1'b0;
      i_err_q      <= 1'b0;
      instr_q      <= '0;
    end else begin
      wb_ack_q <= wb_cyc & wb_o_v & ~wb_o_err;
      wb_err_q <= wb_cyc & wb_o_v & wb_o_err;
      // Write acks leave read data alone; errors carry zero data from the accept stage.
      if (wb_cyc && wb_o_v && (wb_o_err || !wb_o_wr)) wb_rd_data_q <= wb_o_data;
      i_ack_q <= i_o_v & ~i_o_err;
      i_err_q <= i_o_v & i_o_err;
      if (i_o_v) instr_q <= i_o_data;
    end
  end

  assign wb_ack     = wb_ack_q;
  assign wb_err     = wb_err_q;
  assign wb_rd_data = wb_rd_data_q;
  assign instr_ack  = i_ack_q;
  assign instr_err  = i_err_q;
  assign instr      = instr_q;

endmodule

// File: tb/tb_pipelined_main_memory.sv
// Directed bench for pipelined_main_memory at READ_LATENCY=3, 1 KiB, 32-bit words.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_pipelined_main_memory;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_addr;
  logic        instr_stb;
  logic        instr_ack, instr_err;
  logic [31:0] instr;
  logic        wb_cyc, wb_stb, wb_wr_en;
  logic [31:0] wb_addr, wb_wr_data;
  logic [3:0]  wb_wr_sel;
  logic        wb_stall, wb_ack, wb_err;
  logic [31:0] wb_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipelined_main_memory #(
    .MEMORY_HEX   (""),
    .MEMORY_BYTES (1024),
    .DATA_WIDTH   (32),
    .ADDR_WIDTH   (32),
    .READ_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_addr (instr_addr),
    .instr_stb  (instr_stb),
    .instr_ack  (instr_ack),
    .instr_err  (instr_err),
    .instr      (instr),
    .wb_cyc     (wb_cyc),
    .wb_stb     (wb_stb),
    .wb_wr_en   (wb_wr_en),
    .wb_addr    (wb_addr),
    .wb_wr_data (wb_wr_data),
    .wb_wr_sel  (wb_wr_sel),
    .wb_stall   (wb_stall),
    .wb_ack     (wb_ack),
    .wb_err     (wb_err),
    .wb_rd_data (wb_rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wb_expect(input string tag, input logic ack, input logic err, input logic [31:0] data);
    check({tag, ".ack"}, 32'(wb_ack), 32'(ack));
    check({tag, ".err"}, 32'(wb_err), 32'(err));
    check({tag, ".data"}, wb_rd_data, data);
  endtask

  task automatic i_expect(input string tag, input logic ack, input logic err, input logic [31:0] data);
    check({tag, ".ack"}, 32'(instr_ack), 32'(ack));
    check({tag, ".err"}, 32'(instr_err), 32'(err));
    check({tag, ".data"}, instr, data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_set(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    wb_stb     = 1'b1;
    wb_wr_en   = wr;
    wb_addr    = a;
    wb_wr_data = d;
    wb_wr_sel  = sel;
  endtask

  task automatic wb_idle();
    wb_stb    = 1'b0;
    wb_wr_en  = 1'b0;
    wb_wr_sel = 4'h0;
  endtask

  initial begin
    rst = 1'b1; wb_cyc = 1'b0; wb_stb = 1'b0; wb_wr_en = 1'b0;
    wb_addr = '0; wb_wr_data = '0; wb_wr_sel = '0;
    instr_stb = 1'b0; instr_addr = '0;

    tick(); tick();
    check("rst_stall", 32'(wb_stall), 32'd1);
    wb_expect("rst_wb", 1'b0, 1'b0, 32'h0);
    i_expect("rst_i", 1'b0, 1'b0, 32'h0);
    rst = 1'b0; #1;
    check("stall_low", 32'(wb_stall), 32'd0);

    // preload three words back-to-back; first ack lands LAT-1 edges after its accept edge
    wb_cyc = 1'b1;
    wb_set(1'b1, 32'h30, 32'h0000_00AB, 4'hF); tick();
    wb_set(1'b1, 32'h34, 32'h0000_00CD, 4'hF); tick();
    wb_expect("wr_lat", 1'b0, 1'b0, 32'h0);
    wb_set(1'b1, 32'h40, 32'h0000_0011, 4'hF); tick();
    wb_idle();
    wb_expect("wr_ack0", 1'b1, 1'b0, 32'h0);
    tick(); wb_expect("wr_ack1", 1'b1, 1'b0, 32'h0);
    tick(); wb_expect("wr_ack2", 1'b1, 1'b0, 32'h0);
    tick(); wb_expect("wr_done", 1'b0, 1'b0, 32'h0);

    // three pipelined reads, in-order data, no stall, output holds afterwards
    wb_set(1'b0, 32'h38, 32'h0, 4'h0); tick();
    check("rd_stall", 32'(wb_stall), 32'd0);
    wb_set(1'b0, 32'h34, 32'h0, 4'h0); tick();
    wb_expect("rd_lat", 1'b0, 1'b0, 32'h0);
    wb_set(1'b0, 32'h30, 32'h0, 4'h0); tick();
    wb_idle();
    wb_expect("rd0", 1'b1, 1'b0, 32'h0);
    tick(); wb_expect("rd1", 1'b1, 1'b0, 32'h0000_00CD);
    tick(); wb_expect("rd2", 1'b1, 1'b0, 32'h0000_00AB);
    tick(); wb_expect("rd_hold", 1'b0, 1'b0, 32'h0000_00AB);

    // instr port: byte offset ignored, so 0x33 reads word 12 as well
    instr_stb = 1'b1; instr_addr = 32'h30; tick();
    instr_addr = 32'h33; tick();
    instr_stb = 1'b0;
    i_expect("i_lat", 1'b0, 1'b0, 32'h0);
    tick(); i_expect("i0", 1'b1, 1'b0, 32'h0000_00AB);
    tick(); i_expect("i1", 1'b1, 1'b0, 32'h0000_00AB);
    tick(); i_expect("i_hold", 1'b0, 1'b0, 32'h0000_00AB);

    // lane-2-only write, then a read at the very next edge sees it
    wb_set(1'b1, 32'h38, 32'hABCD_EF01, 4'b0100); tick();
    wb_set(1'b0, 32'h38, 32'h0, 4'h0); tick();
    wb_idle();
    tick(); wb_expect("bw_ack", 1'b1, 1'b0, 32'h0000_00AB);
    tick(); wb_expect("bw_rd", 1'b1, 1'b0, 32'h00CD_0000);

    // same-edge write and instr read return old word; next edge returns new
    wb_set(1'b1, 32'h40, 32'h1234_5678, 4'hF);
    instr_stb = 1'b1; instr_addr = 32'h40; tick();
    wb_idle(); tick();
    instr_stb = 1'b0;
    tick();
    i_expect("col_old", 1'b1, 1'b0, 32'h0000_0011);
    wb_expect("col_wack", 1'b1, 1'b0, 32'h00CD_0000);
    tick();
    i_expect("col_new", 1'b1, 1'b0, 32'h1234_5678);

    // out-of-range read/write give err with zero data; 0x3FC is last in-range word and untouched
    wb_set(1'b0, 32'h400, 32'h0, 4'h0);
    instr_stb = 1'b1; instr_addr = 32'h400; tick();
    wb_set(1'b1, 32'h7FC, 32'hDEAD_BEEF, 4'hF);
    instr_stb = 1'b0; tick();
    wb_set(1'b0, 32'h3FC, 32'h0, 4'h0); tick();
    wb_idle();
    wb_expect("oor_rd", 1'b0, 1'b1, 32'h0);
    i_expect("oor_i", 1'b0, 1'b1, 32'h0);
    tick(); wb_expect("oor_wr", 1'b0, 1'b1, 32'h0);
    tick(); wb_expect("last_word", 1'b1, 1'b0, 32'h0);

    // two reads in flight, then wb_cyc low for one edge: neither ever responds
    wb_set(1'b0, 32'h30, 32'h0, 4'h0); tick(); tick();
    wb_idle(); wb_cyc = 1'b0; tick();
    wb_expect("cancel_c", 1'b0, 1'b0, 32'h0);
    wb_cyc = 1'b1;
    for (int i = 0; i < LAT + 1; i++) begin
      tick();
      wb_expect("cancel", 1'b0, 1'b0, 32'h0);
    end

    // reset mid-stream clears outputs and in-flight work, keeps memory
    wb_set(1'b0, 32'h34, 32'h0, 4'h0);
    instr_stb = 1'b1; instr_addr = 32'h34;
    tick(); tick(); tick();
    wb_expect("pre_rst_wb", 1'b1, 1'b0, 32'h0000_00CD);
    i_expect("pre_rst_i", 1'b1, 1'b0, 32'h0000_00CD);
    wb_idle(); instr_stb = 1'b0; rst = 1'b1; #1;
    check("mid_rst_stall", 32'(wb_stall), 32'd1);
    tick();
    wb_expect("mid_rst_wb", 1'b0, 1'b0, 32'h0);
    i_expect("mid_rst_i", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      tick();
      wb_expect("post_rst_wb", 1'b0, 1'b0, 32'h0);
      i_expect("post_rst_i", 1'b0, 1'b0, 32'h0);
    end
    wb_set(1'b0, 32'h30, 32'h0, 4'h0); tick();
    wb_idle(); tick(); tick();
    wb_expect("mem_kept", 1'b1, 1'b0, 32'h0000_00AB);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
